// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths and opcode encodings for the alu slice
// Purpose: DATA_W/OP_W widths and the OP_* opcode constants used by alu_core and alu.
// Ports:   none (package).
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_SLT = 3'b101;
    localparam logic [OP_W-1:0] OP_SLL = 3'b110;
    localparam logic [OP_W-1:0] OP_SRL = 3'b111;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational 4-bit alu datapath
// Purpose: computes result, signed-overflow and zero flags for one operation.
// Ports:   opcode   in  3  operation select
//          src_a    in  4  operand A (two's complement for ADD/SUB/SLT)
//          src_b    in  4  operand B (two's complement for ADD/SUB/SLT)
//          result   out 4  operation result
//          overflow out 1  signed overflow (ADD/SUB only)
//          zero     out 1  result == 0
module alu_core
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              zero
);

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [1:0]        w_shamt;
    logic              w_lt;

    assign w_sum   = src_a + src_b;
    assign w_diff  = src_a - src_b;
    // Only the low two bits of B select the shift distance.
    assign w_shamt = src_b[1:0];
    assign w_lt    = $signed(src_a) < $signed(src_b);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (opcode)
            OP_ADD: begin
                result   = w_sum;
                // Same-sign operands producing a different-sign result.
                overflow = (src_a[DATA_W-1] == src_b[DATA_W-1]) &&
                           (w_sum[DATA_W-1] != src_a[DATA_W-1]);
            end
            OP_SUB: begin
                result   = w_diff;
                // Opposite-sign operands where the result loses A's sign.
                overflow = (src_a[DATA_W-1] != src_b[DATA_W-1]) &&
                           (w_diff[DATA_W-1] != src_a[DATA_W-1]);
            end
            OP_AND:  result = src_a & src_b;
            OP_OR:   result = src_a | src_b;
            OP_XOR:  result = src_a ^ src_b;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, w_lt};
            OP_SLL:  result = src_a << w_shamt;
            OP_SRL:  result = src_a >> w_shamt;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered 4-bit alu, one operation per cycle
// Purpose: wraps alu_core and registers result and flags; one-cycle latency.
// Ports:   clk      in  1  rising-edge clock
//          reset    in  1  asynchronous active-high, clears all outputs
//          opcode   in  3  operation select
//          src_a    in  4  operand A
//          src_b    in  4  operand B
//          alu_out  out 4  registered result
//          overflow out 1  registered signed-overflow flag
//          zero     out 1  registered zero flag
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [DATA_W-1:0] alu_out,
    output logic              overflow,
    output logic              zero
);

    logic [DATA_W-1:0] w_result;
    logic              w_overflow;
    logic              w_zero;

    logic [DATA_W-1:0] r_alu_out;
    logic              r_overflow;
    logic              r_zero;

    alu_core u_core (
        .opcode   (opcode),
        .src_a    (src_a),
        .src_b    (src_b),
        .result   (w_result),
        .overflow (w_overflow),
        .zero     (w_zero)
    );

    // Reset value of zero is 0 even though alu_out is 0000: the flag only
    // describes a computed result, not the cleared state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_out  <= '0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_alu_out  <= w_result;
            r_overflow <= w_overflow;
            r_zero     <= w_zero;
        end
    end

    assign alu_out  = r_alu_out;
    assign overflow = r_overflow;
    assign zero     = r_zero;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed and random self-checking bench for alu
module tb_alu;

    logic       clk;
    logic       reset;
    logic [2:0] opcode;
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] alu_out;
    logic       overflow;
    logic       zero;

    int n_tests;
    int n_fail;

    alu dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .src_a    (src_a),
        .src_b    (src_b),
        .alu_out  (alu_out),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Reference: {ovf, zero, result}, overflow judged on true signed range.
    function automatic logic [5:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int         sa;
        int         sb;
        int         t;
        logic [3:0] r;
        logic       v;
        sa = $signed(a);
        sb = $signed(b);
        r  = 4'b0000;
        v  = 1'b0;
        case (op)
            3'd0: begin t = sa + sb; r = t[3:0]; v = (t > 7) || (t < -8); end
            3'd1: begin t = sa - sb; r = t[3:0]; v = (t > 7) || (t < -8); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? 4'd1 : 4'd0;
            3'd6: begin t = int'(a) * (1 << b[1:0]); r = t[3:0]; end
            default: r = 4'(int'(a) / (1 << b[1:0]));
        endcase
        return {v, (r == 4'b0000), r};
    endfunction

    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        opcode = op;
        src_a  = a;
        src_b  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] er, input logic ev, input logic ez);
        issue(op, a, b);
        check({tag, ".res"}, {4'b0, alu_out}, {4'b0, er});
        check({tag, ".ovf"}, {7'b0, overflow}, {7'b0, ev});
        check({tag, ".zero"}, {7'b0, zero}, {7'b0, ez});
    endtask

    initial begin
        logic [5:0] exp;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        opcode  = 3'd0;
        src_a   = 4'd0;
        src_b   = 4'd0;

        #12;
        check("rst.res",  {4'b0, alu_out}, 8'h00);
        check("rst.ovf",  {7'b0, overflow}, 8'h00);
        check("rst.zero", {7'b0, zero}, 8'h00);

        // Held reset ignores inputs across a clock edge.
        opcode = 3'd3; src_a = 4'hF; src_b = 4'hF;
        @(posedge clk); #1;
        check("rst_hold.res", {4'b0, alu_out}, 8'h00);

        @(negedge clk);
        reset = 1'b0;
        vec("add_basic", 3'd0, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle, away from any clock edge.
        vec("pre_rst", 3'd3, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst.res",  {4'b0, alu_out}, 8'h00);
        check("async_rst.ovf",  {7'b0, overflow}, 8'h00);
        check("async_rst.zero", {7'b0, zero}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        vec("add_ovf",   3'd0, 4'b0111, 4'b0001, 4'b1000, 1'b1, 1'b0);
        vec("add_wrap",  3'd0, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1);
        vec("sub_zero",  3'd1, 4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b1);
        vec("sub_ovf_n", 3'd1, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0);
        vec("sub_ovf_p", 3'd1, 4'b0111, 4'b1111, 4'b1000, 1'b1, 1'b0);
        vec("and",       3'd2, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0);
        vec("or",        3'd3, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0);
        vec("xor_zero",  3'd4, 4'b1010, 4'b1010, 4'b0000, 1'b0, 1'b1);
        vec("slt_true",  3'd5, 4'b1111, 4'b0001, 4'b0001, 1'b0, 1'b0);
        vec("slt_false", 3'd5, 4'b0001, 4'b1111, 4'b0000, 1'b0, 1'b1);
        vec("sll",       3'd6, 4'b0011, 4'b0010, 4'b1100, 1'b0, 1'b0);
        vec("sll_hi_b",  3'd6, 4'b0011, 4'b1101, 4'b0110, 1'b0, 1'b0);
        vec("srl",       3'd7, 4'b1000, 4'b0111, 4'b0001, 1'b0, 1'b0);

        // Back-to-back: a new random operation every cycle.
        for (int i = 0; i < 96; i++) begin
            logic [2:0] op;
            logic [3:0] a;
            logic [3:0] b;
            op = 3'($urandom_range(0, 7));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            exp = model(op, a, b);
            issue(op, a, b);
            check($sformatf("rnd%0d op%0d a%b b%b", i, op, a, b),
                  {2'b0, overflow, zero, alu_out}, {2'b0, exp});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
